// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous-read data memory between CPU and DMA ports with CPU priority and a DMA starvation bound
module dmem_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic              dma_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata
);
  logic [3:0]  streak_cnt;
  logic        rsp_pending, rsp_owner, rsp_ok, cpu_err_q, dma_err_q;
  logic        g_we, bad, ok;
  logic [31:0] g_addr, g_wdata;
  always_comb begin
    cpu_gnt    = !reset && cpu_req && !(dma_req && streak_cnt == 4'(MAX_CPU_STREAK));
    dma_gnt    = !reset && dma_req && !cpu_gnt;
    g_we       = dma_gnt ? dma_we : cpu_we;
    g_addr     = dma_gnt ? dma_addr : cpu_addr;
    g_wdata    = dma_gnt ? dma_wdata : cpu_wdata;
    bad        = (|g_addr[1:0]) || (|g_addr[31:ADDR_W+2]);
    ok         = (cpu_gnt || dma_gnt) && !bad;
    mem_addr   = ok ? g_addr[ADDR_W+1:2] : '0;
    mem_wdata  = ok ? g_wdata : '0;
    mem_we     = ok && g_we;
    mem_re     = ok && !g_we;
    cpu_rvalid = !reset && rsp_pending && !rsp_owner;
    dma_rvalid = !reset && rsp_pending && rsp_owner;
    cpu_rdata  = (cpu_rvalid && rsp_ok) ? mem_rdata : '0;
    dma_rdata  = (dma_rvalid && rsp_ok) ? mem_rdata : '0;
    cpu_err    = !reset && cpu_err_q;
    dma_err    = !reset && dma_err_q;
  end
  // rsp_ok distinguishes a real read from a rejected one that still owes a zero response
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_cnt  <= '0;
      rsp_pending <= 1'b0;
      rsp_owner   <= 1'b0;
      rsp_ok      <= 1'b0;
      cpu_err_q   <= 1'b0;
      dma_err_q   <= 1'b0;
    end else begin
      streak_cnt  <= dma_gnt ? '0 : (cpu_gnt && dma_req) ? streak_cnt + 4'd1 : streak_cnt;
      rsp_pending <= (cpu_gnt || dma_gnt) && !g_we;
      rsp_owner   <= dma_gnt;
      rsp_ok      <= ok;
      cpu_err_q   <= cpu_gnt && bad;
      dma_err_q   <= dma_gnt && bad;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plan plus randomized traffic against a transaction-level reference model
module tb_dmem_arbiter;
  localparam int AW  = 8;
  localparam int MAX = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic cpu_gnt, cpu_rvalid, cpu_err, dma_gnt, dma_rvalid, dma_err, mem_we, mem_re;
  logic [31:0] cpu_rdata, dma_rdata, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem [256] = '{default: 32'h0};
  int total = 0, bad = 0;

  dmem_arbiter #(.ADDR_W(AW), .MAX_CPU_STREAK(MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // memory stand-in: write at the edge, read data appears the cycle after mem_re
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // reference model state: expected memory, streak, outstanding response, pending errors
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  int          m_streak = 0;
  bit          p_valid = 0, p_dma = 0, e_c = 0, e_d = 0;
  logic [31:0] p_data = 0;
  bit          m_ec, m_ed;
  logic        o_cg, o_dg, o_crv, o_cerr, o_drv, o_derr;
  logic [31:0] o_crd, o_drd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit cq, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                       input bit dq, input bit dw, input logic [31:0] da, input logic [31:0] dd);
    bit we_, bad_, ok;
    logic [31:0] a, wd;
    reset = r; cpu_req = cq; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dq; dma_we = dw; dma_addr = da; dma_wdata = dd;
    #4;
    m_ec = !r && cq && !(dq && m_streak == MAX);
    m_ed = !r && dq && (!cq || m_streak == MAX);
    we_  = m_ed ? dw : cw;
    a    = m_ed ? da : ca;
    wd   = m_ed ? dd : cd;
    bad_ = (a % 4 != 0) || (a >= (32'd4 << AW));
    ok   = (m_ec || m_ed) && !bad_;
    check("cpu_gnt", 32'(cpu_gnt), 32'(m_ec));
    check("dma_gnt", 32'(dma_gnt), 32'(m_ed));
    check("one_gnt", 32'(cpu_gnt & dma_gnt), 32'd0);
    check("mem_we", 32'(mem_we), 32'(ok && we_));
    check("mem_re", 32'(mem_re), 32'(ok && !we_));
    if (ok || !(m_ec || m_ed)) begin
      check("mem_addr", 32'(mem_addr), ok ? a >> 2 : 32'd0);
      check("mem_wdata", mem_wdata, ok ? wd : 32'd0);
    end
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(!r && p_valid && !p_dma));
    check("dma_rvalid", 32'(dma_rvalid), 32'(!r && p_valid && p_dma));
    check("cpu_rdata", cpu_rdata, (!r && p_valid && !p_dma) ? p_data : 32'd0);
    check("dma_rdata", dma_rdata, (!r && p_valid && p_dma) ? p_data : 32'd0);
    check("cpu_err", 32'(cpu_err), 32'(!r && e_c));
    check("dma_err", 32'(dma_err), 32'(!r && e_d));
    o_cg = cpu_gnt; o_dg = dma_gnt; o_crv = cpu_rvalid; o_crd = cpu_rdata; o_cerr = cpu_err;
    o_drv = dma_rvalid; o_drd = dma_rdata; o_derr = dma_err;
    @(posedge clk);
    if (r) begin
      m_streak = 0; p_valid = 0; e_c = 0; e_d = 0;
    end else begin
      p_valid = (m_ec || m_ed) && !we_;
      p_dma   = m_ed;
      p_data  = ok ? ref_mem[a >> 2] : 32'd0;
      if (ok && we_) ref_mem[a >> 2] = wd;
      e_c = m_ec && bad_;
      e_d = m_ed && bad_;
      m_streak = m_ed ? 0 : (m_ec && dq) ? m_streak + 1 : m_streak;
    end
    #1;
  endtask

  task automatic idle(input bit r);
    cycle(r, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    int k = $urandom_range(0, 9);
    if (k < 7) return 32'($urandom_range(0, 255)) << 2;
    if (k == 7) return (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
    return 32'($urandom_range(256, 1 << 20)) << 2;
  endfunction

  initial begin
    bit ca_act = 0, da_act = 0, cw_, dw_;
    logic [31:0] ca_, cd_, da_, dd_;
    @(posedge clk); #1;
    idle(1); idle(1); idle(0);
    // DMA loads 0xDEADBEEF into word 3, CPU reads it back
    cycle(0, 0, 0, 0, 0, 1, 1, 32'h0C, 32'hDEADBEEF);
    cycle(0, 1, 0, 32'h0C, 0, 0, 0, 0, 0);
    check("plan_rd_gnt", 32'(o_cg), 32'd1);
    idle(0);
    check("plan_rd_data", o_crd, 32'hDEADBEEF);
    check("plan_rd_dma_rv", 32'(o_drv), 32'd0);
    // DMA write to 0x20 then CPU read
    cycle(0, 0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678);
    cycle(0, 1, 0, 32'h20, 0, 0, 0, 0, 0);
    idle(0);
    check("plan_wr_rd", o_crd, 32'h12345678);
    // misaligned CPU read, out-of-range DMA write
    cycle(0, 1, 0, 32'h6, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 32'h400, 32'h55);
    check("plan_mis_err", 32'(o_cerr), 32'd1);
    idle(0);
    check("plan_oor_err", 32'(o_derr), 32'd1);
    // back-to-back reads of words 0 and 1
    cycle(0, 0, 0, 0, 0, 1, 1, 32'h0, 32'hA0A0A0A0);
    cycle(0, 0, 0, 0, 0, 1, 1, 32'h4, 32'hB1B1B1B1);
    cycle(0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 32'h4, 0);
    check("b2b_cpu", o_crd, 32'hA0A0A0A0);
    idle(0);
    check("b2b_dma", o_drd, 32'hB1B1B1B1);
    // contention from a cleared streak: CPU x4 then DMA, repeating
    idle(1);
    for (int i = 0; i < 15; i++) begin
      cycle(0, 1, 0, 32'h8, 0, 1, 0, 32'h10, 0);
      check("pattern", 32'(o_dg), 32'(i % 5 == 4));
    end
    // reset one cycle after a CPU read grant drops the response
    cycle(0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_rvalid", 32'(o_crv), 32'd0);
    cycle(0, 1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
    check("rst_first_cpu", 32'(o_cg), 32'd1);
    idle(0);
    // randomized traffic: each requester holds its request until the model says it is granted
    for (int n = 0; n < 600; n++) begin
      if (!ca_act && $urandom_range(0, 99) < 60) begin
        ca_act = 1; cw_ = 1'($urandom_range(0, 1)); ca_ = rand_addr(); cd_ = $urandom;
      end
      if (!da_act && $urandom_range(0, 99) < 50) begin
        da_act = 1; dw_ = 1'($urandom_range(0, 1)); da_ = rand_addr(); dd_ = $urandom;
      end
      cycle($urandom_range(0, 99) < 2, ca_act, cw_, ca_, cd_, da_act, dw_, da_, dd_);
      if (m_ec) ca_act = 0;
      if (m_ed) da_act = 0;
    end
    idle(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
